video_timing_gen: RTL



---
 rtl/video_timing_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, registered blanking, sync, SOF/SOL and frame count.
// Define VIDEO_TIMING_CENTER_EN to add the H_OFS/V_OFS sync-centering inputs, latched at frame end.
module video_timing_gen #(
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 21,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 22,
    parameter int RGB_W    = 12,
    parameter int CNT_W    = 9
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             CE_PIX,
    input  logic [RGB_W-1:0] iRGB,
`ifdef VIDEO_TIMING_CENTER_EN
    input  logic [3:0]       H_OFS,
    input  logic [3:0]       V_OFS,
`endif
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             SOF,
    output logic             SOL,
    output logic [7:0]       FRAME
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = CNT_W + 2;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [3:0]       hofs_l;
    logic [3:0]       vofs_l;

    logic             h_last;
    logic             v_last;
    logic             h_blank;
    logic             v_blank;
    logic             h_sync;
    logic             v_sync;
    logic signed [SW-1:0] h_pos_s, v_pos_s;
    logic signed [SW-1:0] hs0, hs1, vs0, vs1;

    assign HPOS = hcnt;
    assign VPOS = vcnt;

    // Sync windows are compared in a signed space two bits wider so a negative offset is safe.
    always_comb begin
        h_last  = (hcnt == CNT_W'(H_TOTAL - 1));
        v_last  = (vcnt == CNT_W'(V_TOTAL - 1));
        h_blank = ({1'b0, hcnt} >= (CNT_W + 1)'(H_ACTIVE));
        v_blank = ({1'b0, vcnt} >= (CNT_W + 1)'(V_ACTIVE));
        h_pos_s = $signed({2'b00, hcnt});
        v_pos_s = $signed({2'b00, vcnt});
        hs0     = SW'(H_ACTIVE + H_FP) + {{(CNT_W - 2){hofs_l[3]}}, hofs_l};
        hs1     = hs0 + SW'(H_SYNC);
        vs0     = SW'(V_ACTIVE + V_FP) + {{(CNT_W - 2){vofs_l[3]}}, vofs_l};
        vs1     = vs0 + SW'(V_SYNC);
        h_sync  = (h_pos_s >= hs0) && (h_pos_s < hs1);
        v_sync  = (v_pos_s >= vs0) && (v_pos_s < vs1);
    end

    // Outputs describe the pixel the counters point at on this enable, so they trail HPOS/VPOS by one CE.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hcnt  <= '0;
            vcnt  <= '0;
            HBLK  <= 1'b1;
            VBLK  <= 1'b1;
            HSYN  <= 1'b1;
            VSYN  <= 1'b1;
            oRGB  <= '0;
            SOF   <= 1'b0;
            SOL   <= 1'b0;
            FRAME <= 8'd0;
        end else if (CE_PIX) begin
            hcnt <= h_last ? '0 : hcnt + CNT_W'(1);
            if (h_last) begin
                vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
                if (v_last) begin
                    FRAME <= FRAME + 8'd1;
                end
            end
            HBLK <= h_blank;
            VBLK <= v_blank;
            HSYN <= ~h_sync;
            VSYN <= ~v_sync;
            oRGB <= (h_blank || v_blank) ? '0 : iRGB;
            SOL  <= (hcnt == '0);
            SOF  <= (hcnt == '0) && (vcnt == '0);
        end
    end

`ifdef VIDEO_TIMING_CENTER_EN
    // Offsets only change between frames so a frame never sees a torn sync position.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hofs_l <= 4'd0;
            vofs_l <= 4'd0;
        end else if (CE_PIX && h_last && v_last) begin
            hofs_l <= H_OFS;
            vofs_l <= V_OFS;
        end
    end
`else
    assign hofs_l = 4'd0;
    assign vofs_l = 4'd0;
`endif

endmodule
